// File: rtl/reset_sequencer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reset_sequencer_pkg : sequencer FSM encoding and sizing helpers  (rev 1.0)
// ---------------------------------------------------------------------------
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } seq_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int cnt_width(input int hold, input int stage);
    return $clog2(max_int(hold, stage) + 1);
  endfunction

  function automatic int idx_width(input int num_ch);
    return max_int(1, $clog2(num_ch));
  endfunction

endpackage
`default_nettype wire

// File: rtl/reset_sequencer_sync_chain.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reset_sync_chain : level synchroniser that powers up / resets to 1  (rev 1.0)
// ---------------------------------------------------------------------------
module reset_sync_chain #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], i_d};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign o_q = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reset_sequencer : merges hard/soft resets, releases NUM_CH domains in order (rev 1.0)
// ---------------------------------------------------------------------------
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int                NUM_CH      = 4,
  parameter int                SYNC_STAGES = 2,
  parameter int                HOLD_CYCLES = 16,
  parameter int                STAGE_DELAY = 8,
  parameter logic [NUM_CH-1:0] CH_SW_MASK  = {NUM_CH{1'b1}}
) (
  input  logic              i_aclk,
  input  logic              i_rst,
  input  logic              i_ext_rst,
  input  logic              i_sw_rst_req,
  output logic              o_sw_rst_ack,
  output logic [NUM_CH-1:0] o_rst_n,
  output logic              o_rst_done,
  output logic              o_busy
);

  localparam int             CW         = cnt_width(HOLD_CYCLES, STAGE_DELAY);
  localparam int             IW         = idx_width(NUM_CH);
  localparam logic [CW-1:0]  HOLD_LAST  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]  STAGE_LAST = CW'(STAGE_DELAY - 1);
  localparam logic [IW-1:0]  IDX_LAST   = IW'(NUM_CH - 1);

  logic ext_sync;
  logic hard_src;

  seq_state_e        state_q,   state_d;
  logic [CW-1:0]     cnt_q,     cnt_d;
  logic [IW-1:0]     idx_q,     idx_d;
  logic              sw_mode_q, sw_mode_d;
  logic [NUM_CH-1:0] rst_n_q,   rst_n_d;
  logic              done_q,    done_d;
  logic              busy_q,    busy_d;
  logic              ack_q,     ack_d;

  reset_sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_ext_sync (
    .i_clk (i_aclk),
    .i_rst (i_rst),
    .i_d   (i_ext_rst),
    .o_q   (ext_sync)
  );

  assign hard_src = i_rst | ext_sync;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    sw_mode_d = sw_mode_q;
    rst_n_d   = rst_n_q;
    done_d    = done_q;
    busy_d    = busy_q;
    ack_d     = 1'b0;

    if (hard_src) begin
      state_d   = ST_ASSERT;
      cnt_d     = '0;
      idx_d     = '0;
      sw_mode_d = 1'b0;
      rst_n_d   = '0;
      done_d    = 1'b0;
      busy_d    = 1'b1;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          // Software sequences leave unmasked channels untouched.
          if (!sw_mode_q) begin
            rst_n_d = '0;
          end
          if (cnt_q == HOLD_LAST) begin
            cnt_d      = '0;
            rst_n_d[0] = 1'b1;
            if (NUM_CH == 1) begin
              state_d = ST_RUN;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end else begin
              state_d = ST_RELEASE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        ST_RELEASE: begin
          if (cnt_q == STAGE_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 1'b1;
            for (int k = 0; k < NUM_CH; k++) begin
              if (idx_d == IW'(k)) begin
                rst_n_d[k] = 1'b1;
              end
            end
            if (idx_d == IDX_LAST) begin
              state_d = ST_RUN;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        ST_RUN: begin
          if (i_sw_rst_req) begin
            state_d   = ST_ASSERT;
            cnt_d     = '0;
            idx_d     = '0;
            sw_mode_d = 1'b1;
            rst_n_d   = rst_n_q & ~CH_SW_MASK;
            done_d    = 1'b0;
            busy_d    = 1'b1;
            ack_d     = 1'b1;
          end
        end

        default: begin
          state_d   = ST_ASSERT;
          cnt_d     = '0;
          idx_d     = '0;
          sw_mode_d = 1'b0;
          rst_n_d   = '0;
          done_d    = 1'b0;
          busy_d    = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge i_aclk) begin
    if (i_rst) begin
      state_q   <= ST_ASSERT;
      cnt_q     <= '0;
      idx_q     <= '0;
      sw_mode_q <= 1'b0;
      rst_n_q   <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b1;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      sw_mode_q <= sw_mode_d;
      rst_n_q   <= rst_n_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
    end
  end

  assign o_rst_n      = rst_n_q;
  assign o_rst_done   = done_q;
  assign o_busy       = busy_q;
  assign o_sw_rst_ack = ack_q;

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_reset_sequencer : directed + random stimulus against a timing model (rev 1.0)
// ---------------------------------------------------------------------------
module tb_reset_sequencer;

  localparam int                NUM_CH = 4;
  localparam int                SYNC   = 2;
  localparam int                HOLD   = 16;
  localparam int                STAGE  = 8;
  localparam logic [NUM_CH-1:0] MASK   = 4'b1100;
  localparam int                MAXE   = 8192;

  logic              clk = 1'b0;
  logic              i_rst;
  logic              i_ext_rst;
  logic              i_sw_rst_req;
  logic              o_sw_rst_ack;
  logic [NUM_CH-1:0] o_rst_n;
  logic              o_rst_done;
  logic              o_busy;

  reset_sequencer #(
    .NUM_CH      (NUM_CH),
    .SYNC_STAGES (SYNC),
    .HOLD_CYCLES (HOLD),
    .STAGE_DELAY (STAGE),
    .CH_SW_MASK  (MASK)
  ) dut (
    .i_aclk       (clk),
    .i_rst        (i_rst),
    .i_ext_rst    (i_ext_rst),
    .i_sw_rst_req (i_sw_rst_req),
    .o_sw_rst_ack (o_sw_rst_ack),
    .o_rst_n      (o_rst_n),
    .o_rst_done   (o_rst_done),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Timing model: every output follows from the edge at which the current
  // sequence began (last hard-source edge or software acceptance edge).
  bit                rst_h [MAXE];
  bit                ext_h [MAXE];
  int                n     = 0;
  int                base  = 0;
  bit                sw    = 1'b0;
  logic [NUM_CH-1:0] mask_v = MASK;
  logic [NUM_CH-1:0] exp_rst_n;
  logic              exp_done = 1'b0;
  logic              exp_busy;
  logic              exp_ack;

  // ext_sync after edge e: the pin value seen SYNC-1 edges earlier, forced to 1
  // for SYNC edges by any i_rst.
  function automatic bit ext_sync_after(input int e);
    if (e < SYNC - 1) return 1'b1;
    for (int m = e - SYNC + 1; m <= e; m++) if (rst_h[m]) return 1'b1;
    return ext_h[e - SYNC + 1];
  endfunction

  always @(posedge clk) begin : model_b
    bit h;
    int el;
    if (n < MAXE) begin
      rst_h[n] = i_rst;
      ext_h[n] = i_ext_rst;
    end
    h       = i_rst | ext_sync_after(n - 1);
    exp_ack = 1'b0;
    if (h) begin
      base = n;
      sw   = 1'b0;
    end else if (exp_done && i_sw_rst_req) begin
      base    = n;
      sw      = 1'b1;
      exp_ack = 1'b1;
    end
    el = n - base;
    for (int k = 0; k < NUM_CH; k++)
      exp_rst_n[k] = (el >= HOLD + k * STAGE) || (sw && !mask_v[k]);
    exp_done = (el >= HOLD + (NUM_CH - 1) * STAGE);
    exp_busy = !exp_done;
    n++;
  end

  always @(negedge clk) begin
    if (n > 0) begin
      chk("model_rst_n", o_rst_n,      exp_rst_n);
      chk("model_done",  o_rst_done,   exp_done);
      chk("model_busy",  o_busy,       exp_busy);
      chk("model_ack",   o_sw_rst_ack, exp_ack);
    end
  end

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    while (!o_rst_done && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (!o_rst_done) begin
      n_chk++;
      $display("FAIL wait_done: o_rst_done=0 expected 1 within %0d cycles", budget);
    end
  endtask

  initial begin
    i_rst        = 1'b1;
    i_ext_rst    = 1'b0;
    i_sw_rst_req = 1'b0;

    // Power-on reset; the synchroniser keeps ext_sync high two extra edges,
    // so ch0 rises 18 edges after the last edge that sampled i_rst=1.
    step(5);
    chk("reset_rst_n", o_rst_n, 4'b0000);
    chk("reset_busy",  o_busy,  1'b1);
    chk("reset_done",  o_rst_done, 1'b0);
    i_rst = 1'b0;
    step(17); chk("t1_pre_ch0", o_rst_n, 4'b0000);
    step(1);  chk("t1_ch0",     o_rst_n, 4'b0001);
    step(8);  chk("t1_ch1",     o_rst_n, 4'b0011);
    step(8);  chk("t1_ch2",     o_rst_n, 4'b0111);
              chk("t1_nodone",  o_rst_done, 1'b0);
    step(8);  chk("t1_ch3",     o_rst_n, 4'b1111);
              chk("t1_done",    o_rst_done, 1'b1);

    // External reset pulse while running.
    step(3);
    i_ext_rst = 1'b1;
    step(3);  chk("t2_assert", o_rst_n, 4'b0000);
    i_ext_rst = 1'b0;
    step(17); chk("t2_pre_ch0", o_rst_n, 4'b0000);
    step(1);  chk("t2_ch0",     o_rst_n, 4'b0001);
    wait_done(100);

    // Software reset with only ch2/ch3 masked.
    step(2);
    i_sw_rst_req = 1'b1;
    step(1);  chk("t3_ack",   o_sw_rst_ack, 1'b1);
              chk("t3_rst_n", o_rst_n, 4'b0011);
    i_sw_rst_req = 1'b0;
    step(1);  chk("t3_ack_end", o_sw_rst_ack, 1'b0);
    step(30); chk("t3_pre_ch2", o_rst_n, 4'b0011);
    step(1);  chk("t3_ch2",     o_rst_n, 4'b0111);
    step(7);  chk("t3_nodone",  o_rst_done, 1'b0);
    step(1);  chk("t3_ch3",     o_rst_n, 4'b1111);
              chk("t3_done",    o_rst_done, 1'b1);

    // i_rst in the middle of a software sequence.
    step(2);
    i_sw_rst_req = 1'b1;
    step(1);
    i_sw_rst_req = 1'b0;
    step(4);
    i_rst = 1'b1;
    step(1);  chk("t4_rst_n", o_rst_n, 4'b0000);
              chk("t4_done",  o_rst_done, 1'b0);
    i_rst = 1'b0;
    step(17); chk("t4_pre_ch0", o_rst_n, 4'b0000);
    step(1);  chk("t4_ch0",     o_rst_n, 4'b0001);

    // Request raised during RELEASE stays pending until RUN.
    i_sw_rst_req = 1'b1;
    for (int c = 0; c < 100 && !o_rst_done; c++) begin
      step(1);
      chk("t5_no_early_ack", o_sw_rst_ack, 1'b0);
    end
    step(1);  chk("t5_ack",   o_sw_rst_ack, 1'b1);
              chk("t5_rst_n", o_rst_n, 4'b0011);
    i_sw_rst_req = 1'b0;
    wait_done(100);

    // Simultaneous hard reset and software request.
    step(2);
    i_rst        = 1'b1;
    i_sw_rst_req = 1'b1;
    step(1);  chk("t6_no_ack", o_sw_rst_ack, 1'b0);
              chk("t6_rst_n",  o_rst_n, 4'b0000);
              chk("t6_busy",   o_busy, 1'b1);
    i_rst        = 1'b0;
    i_sw_rst_req = 1'b0;
    wait_done(100);
    chk("t6_all_high", o_rst_n, 4'b1111);

    // Random mix of all three sources against the model.
    for (int c = 0; c < 4000; c++) begin
      step(1);
      i_rst     = ($urandom_range(0, 599) == 0);
      i_ext_rst = ($urandom_range(0, 249) == 0) ? 1'b1
                : (i_ext_rst && ($urandom_range(0, 2) != 0));
      if (i_sw_rst_req && o_sw_rst_ack)
        i_sw_rst_req = ($urandom_range(0, 3) == 0);
      else if (!i_sw_rst_req && ($urandom_range(0, 39) == 0))
        i_sw_rst_req = 1'b1;
    end
    i_rst        = 1'b0;
    i_ext_rst    = 1'b0;
    i_sw_rst_req = 1'b0;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
